// File: rtl/onehot_pkg.sv
// Shared types and helpers for one-hot / bitmap encoders and future arbiters.
package onehot_pkg;

  localparam int unsigned DEFAULT_W = 64;
  localparam int unsigned MAX_W     = 256;

  typedef enum logic {IDLE, EMIT} enc_state_t;

  // Returns the index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [7:0] lsb_index(input logic [MAX_W-1:0] vec);
    logic [7:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (vec[i] && !found) begin
        idx   = 8'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder built on the shared lsb_index helper.
module lsb_prio_enc
  import onehot_pkg::*;
#(
  parameter  int unsigned W    = DEFAULT_W,
  localparam int unsigned IDXW = $clog2(W)
) (
  input  logic [W-1:0]    vec,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [MAX_W-1:0] w_ext;

  assign w_ext = MAX_W'(vec);
  assign idx   = IDXW'(lsb_index(w_ext));
  assign any   = |vec;

endmodule

// File: rtl/onehot_stream_enc.sv
// Serialises a W-bit bitmap into a valid/ready stream of set-bit indices, lowest first.
module onehot_stream_enc
  import onehot_pkg::*;
#(
  parameter  int unsigned W    = DEFAULT_W,
  localparam int unsigned IDXW = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            zero_drop,
  output logic            busy
);

  enc_state_t      r_state;
  enc_state_t      w_state_nxt;
  logic [W-1:0]    r_pending;
  logic [W-1:0]    w_pending_clr;
  logic            r_zero_drop;
  logic [IDXW-1:0] w_idx;
  logic            w_any;
  logic            w_accept;
  logic            w_load;
  logic            w_fire;

  lsb_prio_enc #(.W(W)) u_lsb_enc (
    .vec (r_pending),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_pending_clr = r_pending & (r_pending - W'(1));
  assign w_accept      = in_valid && in_ready;
  assign w_load        = w_accept && (in_vec != '0);
  assign w_fire        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = EMIT;
      EMIT:    if (w_fire && out_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Index outputs derive only from registered pending, so they hold under backpressure.
  always_comb begin
    in_ready  = (r_state == IDLE) && !rst;
    out_valid = (r_state == EMIT);
    busy      = (r_state == EMIT);
    out_idx   = w_idx;
    out_last  = w_any && (w_pending_clr == '0);
  end

  always_ff @(posedge clk) begin
    if (rst)         r_pending <= '0;
    else if (w_load) r_pending <= in_vec;
    else if (w_fire) r_pending <= w_pending_clr;
  end

  always_ff @(posedge clk) begin
    if (rst) r_zero_drop <= 1'b0;
    else     r_zero_drop <= w_accept && (in_vec == '0);
  end

  assign zero_drop = r_zero_drop;

endmodule

// File: tb/tb_onehot_stream_enc.sv
// Directed bench for onehot_stream_enc with a queue scoreboard of expected indices.
module tb_onehot_stream_enc;

  localparam int unsigned W    = 64;
  localparam int unsigned IDXW = $clog2(W);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_vec;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            zero_drop;
  logic            busy;

  typedef struct {
    int unsigned idx;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_pop = 0;

  onehot_stream_enc #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_drop (zero_drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [W-1:0] vec);
    int hi;
    exp_t e;
    hi = -1;
    for (int i = 0; i < int'(W); i++) if (vec[i]) hi = i;
    for (int i = 0; i < int'(W); i++) begin
      if (vec[i]) begin
        e.idx  = i;
        e.last = (i == hi);
        sb.push_back(e);
      end
    end
  endtask

  // Inputs are driven at the negedge; observe settled outputs, then advance one clock.
  task automatic cycle();
    exp_t e;
    #1;
    if (!rst && in_valid && in_ready) push_model(in_vec);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(out_idx), 64'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("stream_idx", 64'(out_idx), 64'(e.idx));
        chk("stream_last", 64'(out_last), 64'(e.last));
        n_pop++;
      end
    end
    chk("zd_vs_valid", 64'(zero_drop & out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned nb;
    int unsigned base;

    rst = 1'b1; in_valid = 1'b1; in_vec = 64'hFF; out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
    end
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_zd", 64'(zero_drop), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    cycle();
    chk("post_rst_no_out", 64'(out_valid), 64'd0);

    // single bit
    in_valid = 1'b1; in_vec = 64'h8;
    cycle();
    in_valid = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_idx", 64'(out_idx), 64'd3);
    chk("single_last", 64'(out_last), 64'd1);
    chk("single_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("single_idle_ready", 64'(in_ready), 64'd1);
    chk("single_idle_valid", 64'(out_valid), 64'd0);

    // multi-bit streaming
    in_valid = 1'b1; in_vec = 64'h8000_0000_0001_0005;
    cycle();
    in_valid = 1'b0;
    nb = 0;
    for (int c = 0; c < 10 && busy; c++) begin
      nb++;
      cycle();
    end
    chk("multi_busy_cycles", 64'(nb), 64'd4);
    chk("multi_sb_empty", 64'(sb.size()), 64'd0);
    chk("multi_idle_ready", 64'(in_ready), 64'd1);

    // backpressure, with in_vec churning while not ready
    in_valid = 1'b1; in_vec = 64'h6; out_ready = 1'b0;
    cycle();
    repeat (5) begin
      in_valid = 1'b1; in_vec = {$urandom, $urandom};
      #1;
      chk("bp_hold_idx", 64'(out_idx), 64'd1);
      chk("bp_hold_last", 64'(out_last), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_sixth_idx", 64'(out_idx), 64'd1);
    cycle();
    chk("bp_second_idx", 64'(out_idx), 64'd2);
    chk("bp_second_last", 64'(out_last), 64'd1);
    chk("bp_in_ready_emit", 64'(in_ready), 64'd0);
    cycle();
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // zero bitmap
    in_valid = 1'b1; in_vec = '0;
    cycle();
    in_valid = 1'b0;
    chk("zero_pulse", 64'(zero_drop), 64'd1);
    chk("zero_no_valid", 64'(out_valid), 64'd0);
    chk("zero_in_ready", 64'(in_ready), 64'd1);
    cycle();
    chk("zero_pulse_end", 64'(zero_drop), 64'd0);

    // top bit only
    in_valid = 1'b1; in_vec = 64'h8000_0000_0000_0000;
    cycle();
    in_valid = 1'b0;
    chk("top_idx", 64'(out_idx), 64'd63);
    chk("top_last", 64'(out_last), 64'd1);
    cycle();

    // all bits set, drained fully
    in_valid = 1'b1; in_vec = '1;
    cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 100 && sb.size() > 0; c++) cycle();
    chk("full_drain", 64'(sb.size()), 64'd0);
    chk("full_busy_end", 64'(busy), 64'd0);

    // reset mid-stream
    in_valid = 1'b1; in_vec = '1;
    cycle();
    in_valid = 1'b0;
    base = n_pop;
    for (int c = 0; c < 50 && (n_pop - base) < 10; c++) cycle();
    chk("mid_outputs", 64'(n_pop - base), 64'd10);
    rst = 1'b1;
    sb.delete();
    cycle();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_idx", 64'(out_idx), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_post_ready", 64'(in_ready), 64'd1);
    repeat (5) begin
      cycle();
      chk("mid_quiet", 64'(out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_stream_enc.md
Name: onehot_stream_enc

Overview:
Inverse of the codebase's 2-to-4 / one-hot decoders. Accepts a W-bit bitmap, which may have any number of bits set, and serialises it into a stream of binary indices, one per set bit, lowest index first, over a valid/ready handshake. Used where decoded select/request vectors must be turned back into addresses for a downstream consumer.

Parameters:
W, 64, bitmap width; legal range 2..256.
IDXW, $clog2(W), index width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  bitmap offered
in_ready  output  1  block can accept a bitmap
in_vec  input  W  bitmap; sampled only on in_valid && in_ready
out_valid  output  1  out_idx valid
out_ready  input  1  consumer accepts out_idx
out_idx  output  IDXW  index of lowest pending set bit
out_last  output  1  out_idx is the final index of the current bitmap
zero_drop  output  1  one-cycle pulse: an all-zero bitmap was accepted and discarded
busy  output  1  bitmap being serialised (state EMIT)

Behaviour:
- Reset: clk and rst as stated; reset is synchronous and active-high. While rst is high on a clock edge, the block goes to state IDLE with pending=0 and zero_drop=0. During and after reset: out_valid=0, out_last=0, busy=0, out_idx=0. in_ready=0 while rst is high and 1 from the first cycle rst is low. Reset mid-EMIT discards the pending bits with no further outputs.
- State register: pending[W-1:0].
- FSM states: IDLE, EMIT.
- IDLE: in_ready=1, out_valid=0.
  - in_valid=1 and in_vec!=0: pending<=in_vec, go to EMIT.
  - in_valid=1 and in_vec==0: stay in IDLE, zero_drop=1 in the next cycle.
- EMIT: in_ready=0, out_valid=1, busy=1.
  - out_idx = index of the lowest set bit of pending.
  - out_last = (pending has exactly one bit set).
- Output path: out_idx and out_last are combinational from the registered pending value only. They never depend on out_ready or any input, and stay stable while out_valid=1 and out_ready=0.
- Handshake in EMIT: on out_valid && out_ready, clear the lowest set bit of pending (pending & (pending-1)). If out_last=1, go to IDLE.
- Latency: bitmap accepted at edge t gives the first out_valid in cycle t+1. With out_ready held at 1, one index is emitted per cycle. A bitmap with k set bits occupies EMIT for exactly k cycles. One IDLE cycle (in_ready=1) follows every bitmap; there is no back-to-back reload.
- Backpressure: out_ready=0 holds all state. No timeout.
- Boundaries:
  - Bit W-1 set gives out_idx=W-1; no wrap.
  - All W bits set gives W outputs, 0..W-1 in order.
  - in_vec changing while in_ready=0 is ignored.
  - zero_drop never coincides with out_valid.

Decomposition:
- Package onehot_pkg:
  - typedef enum logic {IDLE, EMIT} enc_state_t
  - function lsb_index(vec), which returns the lowest set index and is shared with future arbiters
  - localparam default W=64
- One sub-module, lsb_prio_enc (W), combinational: vec -> idx, any. Instantiated once on pending.
- Everything else lives in onehot_stream_enc.

Test Plan:
- Reset check: rst high 3 cycles with in_valid=1 and in_vec=64'hFF -> out_valid=0 and in_ready=0 throughout; in_ready=1 in the first cycle after rst falls; no output.
- Single bit: in_vec=64'h0000_0000_0000_0008, out_ready=1 -> one cycle later out_idx=3, out_last=1; then IDLE with in_ready=1.
- Multi-bit streaming: in_vec=64'h8000_0000_0001_0005, out_ready=1 -> out_idx 0, 2, 16, 63 on consecutive cycles; out_last=1 only on 63; busy for exactly 4 cycles.
- Backpressure: in_vec=64'h0000_0000_0000_0006, out_ready=0 for 5 cycles, then 1 -> out_idx held at 1 for 6 cycles, then 2 with out_last=1; in_ready=0 throughout EMIT.
- Zero bitmap: in_vec=0 with in_valid=1 -> zero_drop=1 for one cycle, out_valid stays 0, in_ready stays 1.
- Reset mid-EMIT: in_vec=64'hFFFF_FFFF_FFFF_FFFF, rst pulsed after 10 outputs -> out_valid=0 the cycle after the rst edge, no further indices, pending cleared.
